// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART RX control slice: configuration FSM states,
// the set of legal prescale values, reset defaults and parity-type encoding.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IDLE,
    APPLY,
    SETTLE
  } cfg_state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_typ_t;

  localparam int unsigned PRESCALE_8   = 8;
  localparam int unsigned PRESCALE_16  = 16;
  localparam int unsigned PRESCALE_32  = 32;
  localparam int unsigned DEF_PRESCALE = PRESCALE_8;

  function automatic logic prescale_legal(input logic [31:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_sat_cnt.sv
// Saturating event counter used for the RX statistics.
// Ports:
//   i_clk, i_reset (async, active-low)
//   inc   - count one event this cycle
//   clr   - synchronous clear, wins over a same-cycle inc
//   count - current value, sticks at all-ones
module uart_rx_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Control/config sequencer for the UART RX path.
// Holds the active prescale/parity configuration and applies host changes only
// once the RX FSM is idle, keeping new frame starts gated meanwhile. Buffers
// received bytes in a one-entry valid/ready holding register and keeps sticky
// overrun plus saturating frame/parity-error/stop-error statistics.
// Ports:
//   i_clk, i_reset            clock, async active-low reset
//   i_cfg_req/_prescale/_par_en/_par_typ   host config request
//   o_cfg_busy/_ack/_err      config sequence status
//   o_prescale/o_par_en/o_par_typ/o_rx_enable   active config to RX datapath
//   i_rx_busy/_data_valid/_data, i_par_err_evt, i_stp_err_evt   from RX FSM
//   o_data/o_valid/i_ready    holding register handshake
//   o_overrun, i_clr_stats, o_frame_cnt/o_par_err_cnt/o_stp_err_cnt   statistics
module uart_rx_ctrl #(
  parameter int unsigned PRESCALE_W   = 6,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEF_PRESCALE = uart_rx_pkg::DEF_PRESCALE,
  parameter int unsigned SETTLE_CYC   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cfg_req,
  input  logic [PRESCALE_W-1:0] i_cfg_prescale,
  input  logic                  i_cfg_par_en,
  input  logic                  i_cfg_par_typ,
  output logic                  o_cfg_busy,
  output logic                  o_cfg_ack,
  output logic                  o_cfg_err,
  output logic [PRESCALE_W-1:0] o_prescale,
  output logic                  o_par_en,
  output logic                  o_par_typ,
  output logic                  o_rx_enable,
  input  logic                  i_rx_busy,
  input  logic                  i_rx_data_valid,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_par_err_evt,
  input  logic                  i_stp_err_evt,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_overrun,
  input  logic                  i_clr_stats,
  output logic [CNT_W-1:0]      o_frame_cnt,
  output logic [CNT_W-1:0]      o_par_err_cnt,
  output logic [CNT_W-1:0]      o_stp_err_cnt
);

  import uart_rx_pkg::*;

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  cfg_state_t            state, state_nxt;
  logic [SET_W-1:0]      settle_cnt;
  logic [PRESCALE_W-1:0] pend_prescale;
  logic                  pend_par_en;
  logic                  pend_par_typ;
  logic                  req_legal;
  logic                  accept;
  logic                  reject;

  assign req_legal = prescale_legal(32'(i_cfg_prescale));
  assign accept    = (state == IDLE) && i_cfg_req && req_legal;
  assign reject    = (state == IDLE) && i_cfg_req && !req_legal;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // With the RX already idle on the accepting edge, WAIT_IDLE is skipped so
  // the apply lands one cycle after the request.
  always_comb begin
    state_nxt   = state;
    o_rx_enable = 1'b0;
    o_cfg_busy  = 1'b1;
    case (state)
      IDLE: begin
        o_rx_enable = 1'b1;
        o_cfg_busy  = 1'b0;
        if (accept) state_nxt = i_rx_busy ? WAIT_IDLE : APPLY;
      end
      WAIT_IDLE: if (!i_rx_busy) state_nxt = APPLY;
      APPLY:     state_nxt = SETTLE;
      SETTLE:    if (settle_cnt == SET_W'(SETTLE_CYC - 1)) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      settle_cnt    <= '0;
      pend_prescale <= PRESCALE_W'(DEF_PRESCALE);
      pend_par_en   <= 1'b0;
      pend_par_typ  <= PAR_EVEN;
      o_prescale    <= PRESCALE_W'(DEF_PRESCALE);
      o_par_en      <= 1'b0;
      o_par_typ     <= PAR_EVEN;
      o_cfg_ack     <= 1'b0;
      o_cfg_err     <= 1'b0;
    end else begin
      settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
      if (accept) begin
        pend_prescale <= i_cfg_prescale;
        pend_par_en   <= i_cfg_par_en;
        pend_par_typ  <= i_cfg_par_typ;
      end
      if (state == APPLY) begin
        o_prescale <= pend_prescale;
        o_par_en   <= pend_par_en;
        o_par_typ  <= pend_par_typ;
      end
      o_cfg_ack <= (state == APPLY);
      o_cfg_err <= reject;
    end
  end

  // Holding register: a same-cycle pop frees the slot for the incoming byte.
  logic load;
  logic drop;

  assign load = i_rx_data_valid && (!o_valid || i_ready);
  assign drop = i_rx_data_valid && o_valid && !i_ready;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (load) begin
        o_data  <= i_rx_data;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (i_clr_stats) begin
        o_overrun <= 1'b0;
      end else if (drop) begin
        o_overrun <= 1'b1;
      end
    end
  end

  uart_rx_sat_cnt #(.W(CNT_W)) u_frame_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .inc     (i_rx_data_valid),
    .clr     (i_clr_stats),
    .count   (o_frame_cnt)
  );

  uart_rx_sat_cnt #(.W(CNT_W)) u_par_err_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .inc     (i_par_err_evt),
    .clr     (i_clr_stats),
    .count   (o_par_err_cnt)
  );

  uart_rx_sat_cnt #(.W(CNT_W)) u_stp_err_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .inc     (i_stp_err_evt),
    .clr     (i_clr_stats),
    .count   (o_stp_err_cnt)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized self-checking bench for uart_rx_ctrl. The reference model works
// from per-request timelines (request cycle plus RX busy length) and plain
// counters/flags for the holding register and statistics.
module tb_uart_rx_ctrl;

  localparam int unsigned PRESCALE_W = 6;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned MAXC       = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cfg_req;
  logic [PRESCALE_W-1:0] cfg_prescale;
  logic                  cfg_par_en;
  logic                  cfg_par_typ;
  logic                  cfg_busy;
  logic                  cfg_ack;
  logic                  cfg_err;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  par_typ;
  logic                  rx_enable;
  logic                  rx_busy;
  logic                  rx_data_valid;
  logic [7:0]            rx_data;
  logic                  par_err_evt;
  logic                  stp_err_evt;
  logic [7:0]            data;
  logic                  valid;
  logic                  ready;
  logic                  overrun;
  logic                  clr_stats;
  logic [CNT_W-1:0]      frame_cnt;
  logic [CNT_W-1:0]      par_err_cnt;
  logic [CNT_W-1:0]      stp_err_cnt;

  uart_rx_ctrl #(
    .PRESCALE_W (PRESCALE_W),
    .CNT_W      (CNT_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_cfg_req       (cfg_req),
    .i_cfg_prescale  (cfg_prescale),
    .i_cfg_par_en    (cfg_par_en),
    .i_cfg_par_typ   (cfg_par_typ),
    .o_cfg_busy      (cfg_busy),
    .o_cfg_ack       (cfg_ack),
    .o_cfg_err       (cfg_err),
    .o_prescale      (prescale),
    .o_par_en        (par_en),
    .o_par_typ       (par_typ),
    .o_rx_enable     (rx_enable),
    .i_rx_busy       (rx_busy),
    .i_rx_data_valid (rx_data_valid),
    .i_rx_data       (rx_data),
    .i_par_err_evt   (par_err_evt),
    .i_stp_err_evt   (stp_err_evt),
    .o_data          (data),
    .o_valid         (valid),
    .i_ready         (ready),
    .o_overrun       (overrun),
    .i_clr_stats     (clr_stats),
    .o_frame_cnt     (frame_cnt),
    .o_par_err_cnt   (par_err_cnt),
    .o_stp_err_cnt   (stp_err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          cyc;
  bit          seq_active;
  int          seq_t;
  int          seq_b;
  int unsigned new_pre, cur_pre;
  bit          new_pen, cur_pen, new_pt, cur_pt;
  int          err_at;
  bit          m_valid;
  int unsigned m_data;
  bit          m_ovr;
  int unsigned m_frame, m_par, m_stp;

  int unsigned legal_list[3] = '{8, 16, 32};
  int unsigned illegal_list[5] = '{12, 0, 4, 24, 63};

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    seq_active = 0;
    err_at     = -1;
    cur_pre    = 8;
    cur_pen    = 0;
    cur_pt     = 0;
    m_valid    = 0;
    m_data     = 0;
    m_ovr      = 0;
    m_frame    = 0;
    m_par      = 0;
    m_stp      = 0;
  endtask

  task automatic zero_inputs();
    cfg_req       = 0;
    cfg_prescale  = '0;
    cfg_par_en    = 0;
    cfg_par_typ   = 0;
    rx_busy       = 0;
    rx_data_valid = 0;
    rx_data       = '0;
    par_err_evt   = 0;
    stp_err_evt   = 0;
    ready         = 0;
    clr_stats     = 0;
  endtask

  task automatic check_outputs();
    bit gated;
    bit ack_now;
    gated   = seq_active && (cyc >= seq_t + 1) && (cyc <= seq_t + seq_b + 1 + int'(SETTLE_CYC));
    ack_now = seq_active && (cyc == seq_t + seq_b + 2);
    if (ack_now) begin
      cur_pre = new_pre;
      cur_pen = new_pen;
      cur_pt  = new_pt;
    end
    check("rx_enable", 32'(rx_enable), 32'(!gated));
    check("cfg_busy",  32'(cfg_busy),  32'(gated));
    check("cfg_ack",   32'(cfg_ack),   32'(ack_now));
    check("cfg_err",   32'(cfg_err),   32'(cyc == err_at));
    check("prescale",  32'(prescale),  cur_pre);
    check("par_en",    32'(par_en),    32'(cur_pen));
    check("par_typ",   32'(par_typ),   32'(cur_pt));
    check("valid",     32'(valid),     32'(m_valid));
    if (m_valid) check("data", 32'(data), m_data);
    check("overrun",   32'(overrun),   32'(m_ovr));
    check("frame_cnt", 32'(frame_cnt), m_frame);
    check("par_cnt",   32'(par_err_cnt), m_par);
    check("stp_cnt",   32'(stp_err_cnt), m_stp);
    if (seq_active && cyc >= seq_t + seq_b + 2 + int'(SETTLE_CYC)) seq_active = 0;
  endtask

  // mode 0: random; 1: every event each cycle; 2: clear with all events;
  // 3: forced legal request with long RX busy; 4: random without config requests
  task automatic drive_cycle(input int unsigned mode);
    bit          taken, slot_free;
    int unsigned pick;
    zero_inputs();
    if (!seq_active) begin
      rx_busy = 1'($urandom_range(0, 1));
      if (mode == 3 || (mode != 4 && $urandom_range(0, 7) == 0)) begin
        cfg_req     = 1;
        cfg_par_en  = 1'($urandom_range(0, 1));
        cfg_par_typ = 1'($urandom_range(0, 1));
        pick        = $urandom_range(0, 3);
        if (mode == 3) begin
          cfg_prescale = 6'd32;
          cfg_par_en   = 1;
          seq_b        = 5;
        end else if (pick < 3) begin
          cfg_prescale = PRESCALE_W'(legal_list[pick]);
          seq_b        = int'($urandom_range(0, 5));
        end else begin
          cfg_prescale = PRESCALE_W'(illegal_list[$urandom_range(0, 4)]);
          seq_b        = -1;
        end
        if (seq_b >= 0) begin
          seq_active = 1;
          seq_t      = cyc;
          new_pre    = 32'(cfg_prescale);
          new_pen    = cfg_par_en;
          new_pt     = cfg_par_typ;
          rx_busy    = (seq_b > 0);
        end else begin
          err_at = cyc + 1;
        end
      end
    end else begin
      rx_busy = (cyc < seq_t + seq_b);
      if (mode != 4 && $urandom_range(0, 3) == 0) begin
        cfg_req      = 1;
        cfg_prescale = PRESCALE_W'($urandom_range(0, 63));
        cfg_par_en   = 1'($urandom_range(0, 1));
        cfg_par_typ  = 1'($urandom_range(0, 1));
      end
    end

    rx_data = 8'($urandom_range(0, 255));
    ready   = 1'($urandom_range(0, 1));
    if (mode == 1 || mode == 2) begin
      rx_data_valid = 1;
      par_err_evt   = 1;
      stp_err_evt   = 1;
      clr_stats     = (mode == 2);
    end else begin
      rx_data_valid = ($urandom_range(0, 2) == 0);
      par_err_evt   = ($urandom_range(0, 5) == 0);
      stp_err_evt   = ($urandom_range(0, 5) == 0);
      clr_stats     = ($urandom_range(0, 39) == 0);
    end

    taken     = m_valid && ready;
    slot_free = !m_valid || taken;
    if (rx_data_valid && slot_free) begin
      m_valid = 1;
      m_data  = 32'(rx_data);
    end else if (taken) begin
      m_valid = 0;
    end
    if (clr_stats) begin
      m_ovr   = 0;
      m_frame = 0;
      m_par   = 0;
      m_stp   = 0;
    end else begin
      if (rx_data_valid && !slot_free) m_ovr = 1;
      if (rx_data_valid) m_frame = sat_inc(m_frame);
      if (par_err_evt)   m_par   = sat_inc(m_par);
      if (stp_err_evt)   m_stp   = sat_inc(m_stp);
    end
  endtask

  task automatic run(input int unsigned n, input int unsigned mode);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      check_outputs();
      drive_cycle(mode);
      cyc++;
    end
  endtask

  initial begin
    zero_inputs();
    model_reset();
    cyc   = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    check("rst_data", 32'(data), 0);

    run(3000, 0);
    run(300, 1);
    run(1, 2);
    run(200, 0);

    // Reset while a request waits for the RX to go idle
    run(1, 4);
    while (seq_active) run(1, 4);
    run(1, 3);
    run(2, 3);
    @(negedge clk);
    check("pre_rst_busy", 32'(cfg_busy), 1);
    zero_inputs();
    rst_n = 0;
    #1;
    check("rst_prescale", 32'(prescale), 8);
    check("rst_par_en",   32'(par_en), 0);
    check("rst_rx_en",    32'(rx_enable), 1);
    check("rst_busy",     32'(cfg_busy), 0);
    check("rst_valid",    32'(valid), 0);
    check("rst_ovr",      32'(overrun), 0);
    check("rst_frame",    32'(frame_cnt), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cyc   = 0;
    run(20, 4);
    run(500, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
